// File: rtl/sr_pkg.sv
// Shared definitions for the SR command path: the {s,r} command encoding
// used by the downstream SR flop, and the debounce counter width helper.
package sr_pkg;

  // {s,r} encodings, matching the case items of the downstream SR flop
  localparam logic [1:0] SR_CMD_NOP = 2'b00;
  localparam logic [1:0] SR_CMD_RST = 2'b01;
  localparam logic [1:0] SR_CMD_SET = 2'b10;

  // Width needed to count from 0 up to `cycles` inclusive
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sr_debounce_chan.sv
// One button channel: synchroniser chain, debounce counter and rising-edge
// detect. lvl is the debounced level; rise is high for one cycle after lvl
// goes 0->1 (releases produce nothing).
module sr_debounce_chan
  import sr_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic lvl,
  output logic rise
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   lvl_prev_q, lvl_prev_d;
  logic                   y;

  assign y = sync_q[SYNC_STAGES-1];

  // Next-state: shift the synchroniser, run the debounce counter, delay lvl
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d      = cnt_q;
    lvl_d      = lvl_q;
    lvl_prev_d = lvl_q;
    if (y == lvl_q) begin
      // any glitch back to the current level restarts qualification
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      lvl_d = y;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
    end
  end

  assign lvl  = lvl_q;
  assign rise = lvl_q & ~lvl_prev_q;

endmodule

// File: rtl/sr_cmd_debounce.sv
// Command stage in front of the SR flop: two debounced button channels
// feeding a priority register that emits one-cycle s/r pulses, never both.
// Simultaneous presses give r and raise conflict.
// Optional: define SR_CONFLICT_CNT_EN to add conflict_cnt, a saturating
// 8-bit count of conflict pulses.
module sr_cmd_debounce
  import sr_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_btn,
  input  logic       rst_btn,
  output logic       s,
  output logic       r,
  output logic       conflict,
  output logic       set_lvl,
  output logic       rst_lvl
`ifdef SR_CONFLICT_CNT_EN
  ,
  output logic [7:0] conflict_cnt
`endif
);

  logic       set_rise, rst_rise;
  logic [1:0] cmd_q, cmd_d;
  logic       conflict_q, conflict_d;

  sr_debounce_chan #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set_chan (
    .clk  (clk),
    .reset(reset),
    .din  (set_btn),
    .lvl  (set_lvl),
    .rise (set_rise)
  );

  sr_debounce_chan #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_rst_chan (
    .clk  (clk),
    .reset(reset),
    .din  (rst_btn),
    .lvl  (rst_lvl),
    .rise (rst_rise)
  );

  // Priority encode: reset press wins over a simultaneous set press
  always_comb begin
    cmd_d      = SR_CMD_NOP;
    conflict_d = set_rise & rst_rise;
    if (rst_rise) begin
      cmd_d = SR_CMD_RST;
    end else if (set_rise) begin
      cmd_d = SR_CMD_SET;
    end
  end

  // Output command registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd_q      <= SR_CMD_NOP;
      conflict_q <= 1'b0;
    end else begin
      cmd_q      <= cmd_d;
      conflict_q <= conflict_d;
    end
  end

  assign s        = cmd_q[1];
  assign r        = cmd_q[0];
  assign conflict = conflict_q;

`ifdef SR_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt_q, conflict_cnt_d;

  // Saturating conflict counter, advancing together with the conflict flag
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (conflict_d && (conflict_cnt_q != 8'hFF)) begin
      conflict_cnt_d = conflict_cnt_q + 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!reset) begin
      conflict_cnt_q <= 8'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Directed bench for sr_cmd_debounce with default parameters
// (SYNC_STAGES=2, DEBOUNCE_CYCLES=4: press sampled at edge k gives
// set_lvl high after edge k+5 and an s pulse after edge k+6).
module tb_sr_cmd_debounce;

  logic clk = 1'b0;
  logic reset;
  logic set_btn;
  logic rst_btn;
  logic s, r, conflict, set_lvl, rst_lvl;
`ifdef SR_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
`endif

  int vectors = 0;
  int errors  = 0;
  int s_cnt   = 0;
  int r_cnt   = 0;

  always #5 clk = ~clk;

  sr_cmd_debounce #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .set_btn (set_btn),
    .rst_btn (rst_btn),
    .s       (s),
    .r       (r),
    .conflict(conflict),
    .set_lvl (set_lvl),
    .rst_lvl (rst_lvl)
`ifdef SR_CONFLICT_CNT_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n posedges, sampling 1 time unit after each one
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (s === 1'b1) s_cnt++;
      if (r === 1'b1) r_cnt++;
      chk("s_r_exclusive", {31'd0, (s & r)}, 32'd0);
    end
  endtask

  initial begin
    reset   = 1'b0;
    set_btn = 1'b1;
    rst_btn = 1'b1;

    // Reset held 3 cycles with both buttons high
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_s", s, 0);
      chk("rst_r", r, 0);
      chk("rst_conflict", conflict, 0);
      chk("rst_set_lvl", set_lvl, 0);
      chk("rst_rst_lvl", rst_lvl, 0);
    end
    reset   = 1'b1;
    set_btn = 1'b0;
    rst_btn = 1'b0;
    tick(5);
    s_cnt = 0;
    r_cnt = 0;

    // Clean set press
    set_btn = 1'b1;
    tick(1);                      // edge k
    tick(4);                      // k+4
    chk("press_lvl_early", set_lvl, 0);
    tick(1);                      // k+5
    chk("press_lvl_rise", set_lvl, 1);
    chk("press_s_early", s, 0);
    tick(1);                      // k+6
    chk("press_s_pulse", s, 1);
    chk("press_r_low", r, 0);
    chk("press_conflict_low", conflict, 0);
    tick(1);
    chk("press_s_drop", s, 0);
    tick(12);
    chk("press_s_count", s_cnt, 1);
    chk("press_r_count", r_cnt, 0);
    set_btn = 1'b0;
    tick(10);
    chk("release_lvl", set_lvl, 0);
    chk("release_no_pulse", s_cnt, 1);

    // Bounce rejection on rst_btn
    r_cnt = 0;
    rst_btn = 1'b1; tick(1);
    rst_btn = 1'b0; tick(1);
    rst_btn = 1'b1; tick(1);
    rst_btn = 1'b0; tick(1);
    rst_btn = 1'b1;
    tick(1);                      // edge k of stable high
    tick(4);
    chk("bounce_lvl_early", rst_lvl, 0);
    chk("bounce_no_glitch_pulse", r_cnt, 0);
    tick(1);
    chk("bounce_lvl_rise", rst_lvl, 1);
    tick(1);                      // k+6
    chk("bounce_r_pulse", r, 1);
    chk("bounce_s_low", s, 0);
    tick(1);
    chk("bounce_r_drop", r, 0);
    tick(10);
    chk("bounce_r_count", r_cnt, 1);
    rst_btn = 1'b0;
    tick(10);

    // Simultaneous presses: reset wins, conflict flagged
    set_btn = 1'b1;
    rst_btn = 1'b1;
    tick(1);
    tick(5);
    chk("conf_r_early", r, 0);
    tick(1);                      // k+6
    chk("conf_r", r, 1);
    chk("conf_s", s, 0);
    chk("conf_flag", conflict, 1);
`ifdef SR_CONFLICT_CNT_EN
    chk("conf_cnt_one", conflict_cnt, 1);
`endif
    tick(1);
    chk("conf_flag_drop", conflict, 0);
    chk("conf_r_drop", r, 0);
    set_btn = 1'b0;
    rst_btn = 1'b0;
    tick(10);
`ifdef SR_CONFLICT_CNT_EN
    for (int i = 0; i < 300; i++) begin
      set_btn = 1'b1;
      rst_btn = 1'b1;
      tick(10);
      set_btn = 1'b0;
      rst_btn = 1'b0;
      tick(10);
    end
    chk("conf_cnt_sat", conflict_cnt, 8'hFF);
`endif

    // Hold and re-press
    s_cnt   = 0;
    set_btn = 1'b1;
    tick(30);
    chk("hold_one_pulse", s_cnt, 1);
    set_btn = 1'b0;
    tick(10);
    chk("hold_release_none", s_cnt, 1);
    set_btn = 1'b1;
    tick(15);
    chk("repress_second", s_cnt, 2);
    set_btn = 1'b0;
    tick(10);

    // Reset mid-debounce
    set_btn = 1'b1;
    tick(1);                      // edge 40
    tick(2);                      // edge 42
    reset = 1'b0;
    tick(1);                      // edge 43, reset applied
    chk("mid_rst_lvl", set_lvl, 0);
    chk("mid_rst_s", s, 0);
    reset = 1'b1;
    s_cnt = 0;
    tick(1);                      // edge 44
    tick(2);                      // edge 46
    chk("mid_no_pulse", s_cnt, 0);
    tick(3);                      // edge 49
    chk("mid_lvl_rise", set_lvl, 1);
    chk("mid_s_early", s, 0);
    tick(1);                      // edge 50
    chk("mid_s_pulse", s, 1);
    tick(1);
    chk("mid_s_drop", s, 0);
    chk("mid_s_count", s_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
